// File: rtl/video_frame_capture.sv
// Receive-side frame grabber: captures the top-left IMG_W x IMG_H window of one armed frame
// from a VS/HS/DE pixel stream into a frame-buffer write port, and measures the stream format.
module video_frame_capture #(
  parameter int IMG_W    = 225,
  parameter int IMG_H    = 225,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              i_vs,
  input  logic              i_hs,
  input  logic              i_de,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_arm,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_trunc,
  output logic [11:0]       o_width,
  output logic [11:0]       o_height,
  output logic              o_fmt_err
);

  localparam logic [11:0]       CNT_MAX  = 12'hFFF;
  localparam logic [11:0]       IMG_W_C  = 12'(IMG_W);
  localparam logic [11:0]       IMG_H_C  = 12'(IMG_H);
  localparam logic [11:0]       H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0]       V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic              de_q, de_d, de_prev_q, de_prev_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              arm_q, arm_d;
  logic [11:0]       x_q, x_d, y_q, y_d;
  logic              seen_q, seen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              trunc_q, trunc_d;
  logic [11:0]       width_q, width_d;
  logic [11:0]       height_q, height_d;
  logic              fmt_err_q, fmt_err_d;

  logic              frame_start;
  logic              de_fall;
  logic              in_window;

  // HS carries no information this block needs; it is accepted for interface symmetry.
  logic              unused_hs;
  assign unused_hs = i_hs;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
      data_q    <= '0;
      arm_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      seen_q    <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      trunc_q   <= 1'b0;
      width_q   <= '0;
      height_q  <= '0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_d;
      vs_prev_q <= vs_prev_d;
      de_q      <= de_d;
      de_prev_q <= de_prev_d;
      data_q    <= data_d;
      arm_q     <= arm_d;
      x_q       <= x_d;
      y_q       <= y_d;
      seen_q    <= seen_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      trunc_q   <= trunc_d;
      width_q   <= width_d;
      height_q  <= height_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign frame_start = vs_prev_q & ~vs_q;
  assign de_fall     = de_prev_q & ~de_q;
  assign in_window   = de_q && (x_q < IMG_W_C) && (y_q < IMG_H_C);

  always_comb begin
    state_d   = state_q;
    vs_d      = i_vs;
    vs_prev_d = vs_q;
    de_d      = i_de;
    de_prev_d = de_q;
    data_d    = i_data;
    arm_d     = i_arm;
    x_d       = x_q;
    y_d       = y_q;
    seen_d    = seen_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    trunc_d   = 1'b0;
    width_d   = width_q;
    height_d  = height_q;
    fmt_err_d = fmt_err_q;

    if (de_fall) begin
      x_d = '0;
    end else if (de_q && x_q != CNT_MAX) begin
      x_d = x_q + 12'd1;
    end

    if (frame_start) begin
      y_d = '0;
    end else if (de_fall && y_q != CNT_MAX) begin
      y_d = y_q + 12'd1;
    end

    if (de_fall) begin
      width_d = x_q;
    end

    // The width compared here is the freshly updated one, so a line ending on the
    // frame-start cycle is still taken into account.
    if (frame_start) begin
      height_d = y_q;
      seen_d   = 1'b1;
      if (seen_q && (width_d != H_ACT_C || y_q != V_ACT_C)) begin
        fmt_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (arm_q) begin
          state_d   = S_ARMED;
          fmt_err_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (frame_start) begin
          state_d = S_CAPTURE;
          addr_d  = '0;
        end
      end
      S_CAPTURE: begin
        if (frame_start) begin
          state_d = S_DONE;
          trunc_d = 1'b1;
        end else if (in_window) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
          addr_d    = addr_q + ADDR_W'(1);
          if (addr_q == LAST_ADR) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flops follow the next state so they line up with the state register.
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_trunc   = trunc_q;
  assign o_width   = width_q;
  assign o_height  = height_q;
  assign o_fmt_err = fmt_err_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// Directed bench for video_frame_capture using a scaled-down 12x6 active stream and 5x4 window.
module tb_video_frame_capture;

  localparam int IMG_W    = 5;
  localparam int IMG_H    = 4;
  localparam int H_ACTIVE = 12;
  localparam int V_ACTIVE = 6;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int N_PIX    = IMG_W * IMG_H;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_vs = 1'b1;
  logic              i_hs = 1'b1;
  logic              i_de = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              i_arm = 1'b0;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_busy;
  logic              o_done;
  logic              o_trunc;
  logic [11:0]       o_width;
  logic [11:0]       o_height;
  logic              o_fmt_err;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic last_trunc = 1'b0;

  video_frame_capture #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .i_data(i_data), .i_arm(i_arm), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done), .o_trunc(o_trunc),
    .o_width(o_width), .o_height(o_height), .o_fmt_err(o_fmt_err)
  );

  always #5 clk_i = ~clk_i;

  // Every write must land at the next contiguous address with pixel (x+y) of the window.
  always @(negedge clk_i) begin
    if (rst_n) begin
      if (o_wr_en) begin
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        exp_addr = ADDR_W'(wr_cnt);
        exp_data = DATA_W'((wr_cnt % IMG_W) + (wr_cnt / IMG_W));
        total++;
        if (o_wr_addr !== exp_addr || o_wr_data !== exp_data) begin
          bad++;
          $display("FAIL write#%0d: addr=%0d data=%0d expected addr=%0d data=%0d",
                   wr_cnt, o_wr_addr, o_wr_data, exp_addr, exp_data);
        end else begin
          $display("write addr=%0d data=%0d", o_wr_addr, o_wr_data);
        end
        wr_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        last_trunc = o_trunc;
        $display("done trunc=%0b", o_trunc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      i_vs = 1'b1; i_hs = 1'b1; i_de = 1'b0; i_data = '0;
    end
  endtask

  // Frame: 2 VS lines, 1 back-porch line, `lines` active lines, 1 front-porch line.
  task automatic send_frame(input int w, input int lines);
    for (int l = 0; l < lines + 4; l++) begin
      for (int c = 0; c < w + 4; c++) begin
        @(posedge clk_i); #1;
        i_vs = (l < 2) ? 1'b0 : 1'b1;
        i_hs = (c >= w + 1 && c < w + 3) ? 1'b0 : 1'b1;
        i_de = (l >= 3 && l < 3 + lines && c < w);
        i_data = i_de ? DATA_W'(c + l - 3) : '0;
      end
    end
    @(posedge clk_i); #1;
    i_vs = 1'b1; i_hs = 1'b1; i_de = 1'b0; i_data = '0;
  endtask

  task automatic pulse_arm();
    @(posedge clk_i); #1; i_arm = 1'b1;
    @(posedge clk_i); #1; i_arm = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end else begin
      $display("check %s = %0d", name, got);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_trunc, o_width, o_height, o_fmt_err} !== '0) begin
      bad++;
      $display("FAIL %s: wr_en=%0b addr=%0d data=%0d busy=%0b done=%0b trunc=%0b w=%0d h=%0d fmt=%0b expected all 0",
               name, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_trunc, o_width, o_height, o_fmt_err);
    end else begin
      $display("check %s all outputs 0", name);
    end
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(3);
    check_all_zero("after_reset_release");
  endtask

  task automatic test_full_capture();
    send_frame(H_ACTIVE, V_ACTIVE);
    pulse_arm();
    idle(2);
    check_val("t1_busy_armed", int'(o_busy), 1);
    wr_cnt = 0; done_cnt = 0;
    send_frame(H_ACTIVE, V_ACTIVE);
    idle(4);
    check_val("t1_writes", wr_cnt, N_PIX);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_trunc", int'(last_trunc), 0);
    check_val("t1_busy_after", int'(o_busy), 0);
    check_val("t1_width", int'(o_width), H_ACTIVE);
    check_val("t1_height", int'(o_height), V_ACTIVE);
    check_val("t1_fmt_err", int'(o_fmt_err), 0);
  endtask

  task automatic test_arm_mid_frame();
    wr_cnt = 0; done_cnt = 0;
    fork
      send_frame(H_ACTIVE, V_ACTIVE);
      begin
        repeat (60) @(posedge clk_i);
        pulse_arm();
      end
    join
    idle(4);
    check_val("t2_no_early_writes", wr_cnt, 0);
    check_val("t2_busy_waiting", int'(o_busy), 1);
    send_frame(H_ACTIVE, V_ACTIVE);
    idle(4);
    check_val("t2_writes", wr_cnt, N_PIX);
    check_val("t2_done_cnt", done_cnt, 1);
  endtask

  task automatic test_fmt_err();
    send_frame(10, V_ACTIVE);
    idle(4);
    check_val("t3_width", int'(o_width), 10);
    check_val("t3_fmt_before", int'(o_fmt_err), 0);
    send_frame(10, V_ACTIVE);
    idle(4);
    check_val("t3_fmt_set", int'(o_fmt_err), 1);
    pulse_arm();
    idle(2);
    check_val("t3_fmt_cleared", int'(o_fmt_err), 0);
    wr_cnt = 0; done_cnt = 0;
    send_frame(H_ACTIVE, V_ACTIVE);
    idle(4);
    check_val("t3_capture_writes", wr_cnt, N_PIX);
  endtask

  task automatic test_truncation();
    pulse_arm();
    wr_cnt = 0; done_cnt = 0;
    send_frame(H_ACTIVE, 2);
    idle(4);
    check_val("t4_partial_writes", wr_cnt, 2 * IMG_W);
    check_val("t4_no_done_yet", done_cnt, 0);
    send_frame(H_ACTIVE, V_ACTIVE);
    idle(4);
    check_val("t4_writes", wr_cnt, 2 * IMG_W);
    check_val("t4_done_cnt", done_cnt, 1);
    check_val("t4_trunc", int'(last_trunc), 1);
  endtask

  task automatic test_reset_mid_capture();
    bit reached;
    pulse_arm();
    wr_cnt = 0; done_cnt = 0;
    reached = 1'b0;
    fork
      send_frame(H_ACTIVE, V_ACTIVE);
      begin
        for (int i = 0; i < 400 && !reached; i++) begin
          @(negedge clk_i); #1;
          if (wr_cnt >= 7) reached = 1'b1;
        end
        if (reached) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("t5_reset_abort");
          repeat (3) @(posedge clk_i);
          #1 rst_n = 1'b1;
        end
      end
    join
    check_val("t5_reached_write7", int'(reached), 1);
    idle(4);
    check_val("t5_writes_frozen", wr_cnt, 7);
    check_val("t5_no_done", done_cnt, 0);
    check_val("t5_idle_busy", int'(o_busy), 0);
    pulse_arm();
    wr_cnt = 0; done_cnt = 0;
    send_frame(H_ACTIVE, V_ACTIVE);
    idle(4);
    check_val("t5_rearm_writes", wr_cnt, N_PIX);
    check_val("t5_rearm_done", done_cnt, 1);
  endtask

  task automatic test_vs_held_high();
    send_frame(10, V_ACTIVE);
    send_frame(10, V_ACTIVE);
    idle(4);
    check_val("t6_fmt_set", int'(o_fmt_err), 1);
    wr_cnt = 0; done_cnt = 0;
    pulse_arm();
    idle(50);
    check_val("t6_busy", int'(o_busy), 1);
    check_val("t6_fmt_cleared", int'(o_fmt_err), 0);
    pulse_arm();
    idle(50);
    check_val("t6_busy_second_arm", int'(o_busy), 1);
    check_val("t6_fmt_unchanged", int'(o_fmt_err), 0);
    check_val("t6_no_writes", wr_cnt, 0);
    check_val("t6_no_done", done_cnt, 0);
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_arm_mid_frame();
    test_fmt_err();
    test_truncation();
    test_reset_mid_capture();
    test_vs_held_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
